instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Program sequencer that replaces the free-running counter feeding the instruction memory address.
//  Holds a program counter (PC), replays the stored program for a programmable number of epochs and supports start, stall and abort.
//  Reports busy/done status to the testbench or host.
//  Sits upstream of the autoencoder datapath: pc -> instruction memory address; fetch_valid qualifies the issued word.
// PARAMETERS
//  ADDR_W   16  PC / program-length width (instruction memory depth <= 2**ADDR_W)
//  EPOCH_W  16  epoch counter width
//  HALT_OP  4'hF  opcode (instr[15:12]) that ends the current epoch early
// PORTS
//  clock        in   1        rising-edge clock
//  rst_n        in   1        asynchronous active-low reset
//  start        in   1        1-cycle request to begin a run; sampled only in IDLE
//  abort        in   1        synchronous abort; highest priority after reset
//  stall        in   1        freeze PC and epoch counter this cycle
//  prog_len     in   ADDR_W   instructions per epoch; sampled on accepted start
//  epoch_count  in   EPOCH_W  epochs to run; sampled on accepted start
//  instr        in   16       word read at current pc (combinational memory read)
//  pc           out  ADDR_W   instruction memory address
//  fetch_valid  out  1        instr at pc is to be executed this cycle
//  epoch_idx    out  EPOCH_W  current epoch, 0-based
//  busy         out  1        high in RUN
//  done         out  1        1-cycle pulse on run completion
// BEHAVIOUR
//  Reset values:
//   - pc=0, epoch_idx=0, fetch_valid=0, busy=0, done=0.
//   - State=IDLE; latched length/count=0.
//  States: IDLE, RUN, DONE.
//  IDLE:
//   - start=1 with prog_len!=0 and epoch_count!=0: latch both, pc<=0, epoch_idx<=0, go to RUN.
//   - start=1 with either input =0: go straight to DONE.
//   - Otherwise remain in IDLE.
//  RUN:
//   - busy=1; fetch_valid = ~stall.
//   - stall=1: pc and epoch_idx hold; instr is not executed.
//   - End of epoch is (pc==len-1 OR instr[15:12]==HALT_OP) with stall=0.
//   - Not at end of epoch: pc<=pc+1.
//   - At end of epoch and epoch_idx==count-1: go to DONE; pc and epoch_idx hold.
//   - At end of epoch otherwise: pc<=0, epoch_idx<=epoch_idx+1.
//   - The HALT word itself has fetch_valid=1, so the datapath can decode it as a no-op.
//  DONE:
//   - done=1 and fetch_valid=0 for exactly one cycle, then IDLE.
//   - pc and epoch_idx keep their final values until the next accepted start.
//  abort=1 in any state: next state IDLE; pc<=0, epoch_idx<=0, fetch_valid=0, busy=0; done is NOT pulsed.
//  Simultaneous events:
//   - start while busy, or in DONE: ignored.
//   - abort together with start: abort wins.
//  Reset asserted mid-run: all outputs go to their reset values immediately (asynchronous). Recovery is a fresh start.
//  Arithmetic: unsigned; pc+1 is modulo 2**ADDR_W but never wraps because len<=2**ADDR_W-1.
//  Latency: start accepted at edge N -> pc=0 with fetch_valid=1 during cycle N+1.
// STRUCTURE
//  Shared package: state encoding (IDLE=2'd0, RUN=2'd1, DONE=2'd2), the opcode constants including HALT_OP, and ADDR_W.
//  One sub-module, seq_counter:
//   - Loadable up-counter with enable, synchronous clear and asynchronous reset.
//   - Instantiated twice: once for the PC, once for epoch_idx.
//  FSM and end-of-epoch compare stay in the top module; registered outputs only, except fetch_valid = (state==RUN) & ~stall.
// TESTING
//  1. Basic run: prog_len=4, epoch_count=1, pulse start -> pc 0,1,2,3 on consecutive cycles with fetch_valid=1; done pulses on the cycle after pc=3; then IDLE.
//  2. Multi-epoch: prog_len=3, epoch_count=3 -> pc sequence 0,1,2 repeated three times; epoch_idx 0->1->2; exactly 9 fetch_valid cycles; one done pulse.
//  3. Stall: prog_len=5; hold stall for 2 cycles at pc=2 -> pc stays 2 with fetch_valid=0; resumes at 3; 5 valid fetches total.
//  4. HALT: prog_len=8, epoch_count=2, instr=16'hF000 at pc=3 -> each epoch ends after pc=3; done is pulsed after the 2nd epoch's pc=3.
//  5. Boundary: start with prog_len=0 -> done pulses next cycle, busy never rises. start during RUN -> no effect on pc or epoch_idx.
//  6. Abort and reset: abort at pc=2, epoch 1 -> IDLE next cycle, pc=0, no done. Deassert rst_n mid-run -> outputs 0 immediately; a new start runs cleanly.

Source files
------------

// File: rtl/instr_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// instr_sequencer_pkg
//   Definitions shared by the program sequencer and its counter sub-module.
//   Contents:
//     - ADDR_W, EPOCH_W : default PC / epoch counter widths
//     - HALT_OP         : opcode (instr[15:12]) that ends an epoch early
//     - seq_state_t     : sequencer FSM state encoding
//     - opcode_of()     : extracts the opcode field of an instruction word
// ---------------------------------------------------------------------------
package instr_sequencer_pkg;

   localparam int ADDR_W   = 16;
   localparam int EPOCH_W  = 16;
   localparam int OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] HALT_OP = 4'hF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } seq_state_t;

   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [15:0] word);
      return word[15:12];
   endfunction

endpackage

// File: rtl/instr_sequencer_seq_counter.sv
// ---------------------------------------------------------------------------
// seq_counter
//   Loadable up-counter with enable, synchronous clear and asynchronous
//   active-low reset. Priority: clear > load > en.
//   Ports:
//     clock    in  1  rising-edge clock
//     rst_n    in  1  asynchronous active-low reset (count -> 0)
//     clear    in  1  synchronous clear to 0
//     load     in  1  synchronous load of load_val
//     load_val in  W  value loaded when load=1
//     en       in  1  increment by one (modulo 2**W)
//     count    out W  current count
// ---------------------------------------------------------------------------
module seq_counter #(
   parameter int W = 16
) (
   input  logic         clock,
   input  logic         rst_n,
   input  logic         clear,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic [W-1:0] count
);

   logic [W-1:0] count_reg;

   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         count_reg <= '0;
      end else if (clear) begin
         count_reg <= '0;
      end else if (load) begin
         count_reg <= load_val;
      end else if (en) begin
         count_reg <= count_reg + W'(1);
      end
   end

   assign count = count_reg;

endmodule

// File: rtl/instr_sequencer.sv
// ---------------------------------------------------------------------------
// instr_sequencer
//   Program sequencer driving the instruction memory address. Replays a
//   program of prog_len words for epoch_count epochs, with stall and abort.
//   Ports:
//     clock       in  1        rising-edge clock
//     rst_n       in  1        asynchronous active-low reset
//     start       in  1        run request, honoured only in IDLE
//     abort       in  1        synchronous abort back to IDLE (no done pulse)
//     stall       in  1        freeze pc / epoch_idx this cycle
//     prog_len    in  ADDR_W   instructions per epoch, latched on start
//     epoch_count in  EPOCH_W  epochs to run, latched on start
//     instr       in  16       instruction word at pc (combinational read)
//     pc          out ADDR_W   instruction memory address
//     fetch_valid out 1        instr at pc is executed this cycle
//     epoch_idx   out EPOCH_W  current epoch, 0-based
//     busy        out 1        high while running
//     done        out 1        one-cycle completion pulse
// ---------------------------------------------------------------------------
module instr_sequencer #(
   parameter int          ADDR_W  = instr_sequencer_pkg::ADDR_W,
   parameter int          EPOCH_W = instr_sequencer_pkg::EPOCH_W,
   parameter logic [3:0]  HALT_OP = instr_sequencer_pkg::HALT_OP
) (
   input  logic               clock,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic               stall,
   input  logic [ADDR_W-1:0]  prog_len,
   input  logic [EPOCH_W-1:0] epoch_count,
   input  logic [15:0]        instr,
   output logic [ADDR_W-1:0]  pc,
   output logic               fetch_valid,
   output logic [EPOCH_W-1:0] epoch_idx,
   output logic               busy,
   output logic               done
);

   import instr_sequencer_pkg::*;

   seq_state_t         state_reg, state_next;
   logic [ADDR_W-1:0]  len_reg;
   logic [EPOCH_W-1:0] count_reg;
   logic               busy_reg, done_reg;

   logic               latch_cfg;
   logic               pc_clear, pc_en;
   logic               ep_clear, ep_en;
   logic               end_of_epoch, last_epoch;

   // ------------------------------------------------------------------
   // Counters
   // ------------------------------------------------------------------
   seq_counter #(.W(ADDR_W)) u_pc_counter (
      .clock    (clock),
      .rst_n    (rst_n),
      .clear    (pc_clear),
      .load     (1'b0),
      .load_val ({ADDR_W{1'b0}}),
      .en       (pc_en),
      .count    (pc)
   );

   seq_counter #(.W(EPOCH_W)) u_epoch_counter (
      .clock    (clock),
      .rst_n    (rst_n),
      .clear    (ep_clear),
      .load     (1'b0),
      .load_val ({EPOCH_W{1'b0}}),
      .en       (ep_en),
      .count    (epoch_idx)
   );

   // ------------------------------------------------------------------
   // End-of-epoch detection. len_reg is never 0 while in RUN, so the
   // len-1 compare cannot underflow when it matters.
   // ------------------------------------------------------------------
   assign end_of_epoch = (pc == (len_reg - ADDR_W'(1))) ||
                         (opcode_of(instr) == HALT_OP);
   assign last_epoch   = (epoch_idx == (count_reg - EPOCH_W'(1)));

   // ------------------------------------------------------------------
   // State and registered status
   // ------------------------------------------------------------------
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
         len_reg   <= '0;
         count_reg <= '0;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         if (latch_cfg) begin
            len_reg   <= prog_len;
            count_reg <= epoch_count;
         end
         // Status flags are registered copies of the state being entered,
         // so they line up exactly with RUN / DONE.
         busy_reg <= (state_next == ST_RUN);
         done_reg <= (state_next == ST_DONE);
      end
   end

   // ------------------------------------------------------------------
   // Next-state and counter control
   // ------------------------------------------------------------------
   always_comb begin
      state_next = state_reg;
      latch_cfg  = 1'b0;
      pc_clear   = 1'b0;
      pc_en      = 1'b0;
      ep_clear   = 1'b0;
      ep_en      = 1'b0;

      if (abort) begin
         state_next = ST_IDLE;
         pc_clear   = 1'b1;
         ep_clear   = 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (start) begin
                  if ((prog_len != '0) && (epoch_count != '0)) begin
                     latch_cfg  = 1'b1;
                     pc_clear   = 1'b1;
                     ep_clear   = 1'b1;
                     state_next = ST_RUN;
                  end else begin
                     // Empty run: report completion without executing.
                     state_next = ST_DONE;
                  end
               end
            end
            ST_RUN: begin
               if (!stall) begin
                  if (end_of_epoch) begin
                     if (last_epoch) begin
                        // pc / epoch_idx keep their final values.
                        state_next = ST_DONE;
                     end else begin
                        pc_clear = 1'b1;
                        ep_en    = 1'b1;
                     end
                  end else begin
                     pc_en = 1'b1;
                  end
               end
            end
            ST_DONE: begin
               state_next = ST_IDLE;
            end
            default: begin
               state_next = ST_IDLE;
            end
         endcase
      end
   end

   assign fetch_valid = (state_reg == ST_RUN) && !stall;
   assign busy        = busy_reg;
   assign done        = done_reg;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;

   logic        clock = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic        stall;
   logic [15:0] prog_len;
   logic [15:0] epoch_count;
   logic [15:0] instr;
   logic [15:0] pc;
   logic        fetch_valid;
   logic [15:0] epoch_idx;
   logic        busy;
   logic        done;

   int tests_run = 0;
   int tests_failed = 0;

   logic [15:0] prog_mem [0:255];
   int          last_pc = 0;
   int          last_ep = 0;

   typedef struct {
      int p;
      int e;
   } fetch_t;

   always #5 clock = ~clock;

   // Combinational instruction memory read
   assign instr = prog_mem[pc[7:0]];

   instr_sequencer dut (
      .clock       (clock),
      .rst_n       (rst_n),
      .start       (start),
      .abort       (abort),
      .stall       (stall),
      .prog_len    (prog_len),
      .epoch_count (epoch_count),
      .instr       (instr),
      .pc          (pc),
      .fetch_valid (fetch_valid),
      .epoch_idx   (epoch_idx),
      .busy        (busy),
      .done        (done)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         tests_failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill_mem(input int halt_at);
      for (int i = 0; i < 256; i++)
         prog_mem[i] = {4'($urandom_range(14)), 12'($urandom)};
      if (halt_at >= 0) prog_mem[halt_at] = 16'hF000;
   endtask

   // Runs one program. Expected fetch trace is derived from the rules:
   // each epoch walks addresses 0..len-1, cut short just after a HALT word.
   // Called and returns at posedge+1.
   task automatic run_prog(input int len, input int cnt, input int stall_pct,
                           input int stall_pc, input bit noise, input string name);
      fetch_t q[$];
      int     idx = 0;
      int     guard = 0;
      int     stall_left = 2;
      int     fetches = 0;
      bit     s;
      for (int e = 0; e < cnt; e++) begin
         for (int p = 0; p < len; p++) begin
            q.push_back('{p, e});
            if (prog_mem[p][15:12] == 4'hF) break;
         end
      end
      prog_len    = 16'(len);
      epoch_count = 16'(cnt);
      start       = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      while (idx < q.size()) begin
         s = 1'b0;
         if (stall_pc >= 0 && q[idx].p == stall_pc && stall_left > 0) begin
            s = 1'b1;
            stall_left--;
         end else if (guard < 200 && $urandom_range(99) < stall_pct) begin
            s = 1'b1;
         end
         stall = s;
         if (noise) begin
            start       = ($urandom_range(7) == 0);
            prog_len    = 16'($urandom);
            epoch_count = 16'($urandom);
         end
         #1;
         check({name, " pc"}, 32'(pc), q[idx].p);
         check({name, " epoch_idx"}, 32'(epoch_idx), q[idx].e);
         check({name, " busy"}, 32'(busy), 1);
         check({name, " fetch_valid"}, 32'(fetch_valid), 32'(!s));
         check({name, " done_in_run"}, 32'(done), 0);
         if (!s) begin
            idx++;
            fetches++;
         end
         guard++;
         @(posedge clock); #1;
      end
      // DONE cycle; a start here must be ignored
      stall = 1'b0;
      start = noise ? 1'($urandom_range(1)) : 1'b0;
      #1;
      check({name, " done_pulse"}, 32'(done), 1);
      check({name, " busy_done"}, 32'(busy), 0);
      check({name, " fv_done"}, 32'(fetch_valid), 0);
      check({name, " pc_final"}, 32'(pc), q[q.size()-1].p);
      check({name, " epoch_final"}, 32'(epoch_idx), q[q.size()-1].e);
      check({name, " fetch_count"}, fetches, q.size());
      @(posedge clock); #1;
      start = 1'b0;
      check({name, " done_one_cycle"}, 32'(done), 0);
      check({name, " idle_busy"}, 32'(busy), 0);
      check({name, " pc_hold"}, 32'(pc), q[q.size()-1].p);
      last_pc = q[q.size()-1].p;
      last_ep = q[q.size()-1].e;
      $display("[TB] run %s len=%0d epochs=%0d fetches=%0d", name, len, cnt, fetches);
   endtask

   initial begin
      rst_n       = 1'b0;
      start       = 1'b0;
      abort       = 1'b0;
      stall       = 1'b0;
      prog_len    = '0;
      epoch_count = '0;
      fill_mem(-1);
      #12;
      check("reset pc", 32'(pc), 0);
      check("reset epoch_idx", 32'(epoch_idx), 0);
      check("reset busy", 32'(busy), 0);
      check("reset done", 32'(done), 0);
      check("reset fetch_valid", 32'(fetch_valid), 0);
      @(posedge clock); #1;
      rst_n = 1'b1;
      @(posedge clock); #1;
      check("idle busy", 32'(busy), 0);

      // Directed scenarios
      fill_mem(-1);
      run_prog(4, 1, 0, -1, 1'b0, "basic");
      run_prog(3, 3, 0, -1, 1'b0, "multi_epoch");
      run_prog(5, 1, 0, 2, 1'b0, "stall");
      fill_mem(3);
      run_prog(8, 2, 0, -1, 1'b0, "halt");

      // Zero-length / zero-epoch starts: done next cycle, busy never rises
      prog_len = 16'd0; epoch_count = 16'd3; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("len0 done", 32'(done), 1);
      check("len0 busy", 32'(busy), 0);
      check("len0 pc_hold", 32'(pc), last_pc);
      @(posedge clock); #1;
      check("len0 done_off", 32'(done), 0);
      check("len0 busy_off", 32'(busy), 0);
      $display("[TB] zero-length start checked");
      prog_len = 16'd5; epoch_count = 16'd0; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      check("cnt0 done", 32'(done), 1);
      check("cnt0 busy", 32'(busy), 0);
      @(posedge clock); #1;
      check("cnt0 done_off", 32'(done), 0);
      $display("[TB] zero-epoch start checked");

      // Randomized runs with stalls, stray starts and random HALT placement
      for (int r = 0; r < 12; r++) begin
         int len;
         len = $urandom_range(20, 1);
         fill_mem(($urandom_range(2) == 0) ? int'($urandom_range(len - 1)) : -1);
         run_prog(len, $urandom_range(4, 1), 30, -1, 1'b1, $sformatf("rand%0d", r));
      end

      // Abort at pc=2, epoch 1
      fill_mem(-1);
      prog_len = 16'd4; epoch_count = 16'd3; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (6) @(posedge clock);
      #1;
      check("abort pre pc", 32'(pc), 2);
      check("abort pre epoch", 32'(epoch_idx), 1);
      abort = 1'b1;
      @(posedge clock); #1;
      abort = 1'b0;
      check("abort pc", 32'(pc), 0);
      check("abort epoch", 32'(epoch_idx), 0);
      check("abort busy", 32'(busy), 0);
      check("abort fv", 32'(fetch_valid), 0);
      check("abort done", 32'(done), 0);
      @(posedge clock); #1;
      check("abort no_done", 32'(done), 0);
      check("abort idle", 32'(busy), 0);
      $display("[TB] abort mid-run checked");

      // Abort together with start: abort wins
      prog_len = 16'd4; epoch_count = 16'd1; start = 1'b1; abort = 1'b1;
      @(posedge clock); #1;
      start = 1'b0; abort = 1'b0;
      check("abort_start busy", 32'(busy), 0);
      check("abort_start fv", 32'(fetch_valid), 0);
      $display("[TB] abort+start checked");

      // Asynchronous reset mid-run, then a clean fresh run
      prog_len = 16'd10; epoch_count = 16'd2; start = 1'b1;
      @(posedge clock); #1;
      start = 1'b0;
      repeat (5) @(posedge clock);
      #1;
      check("prereset pc", 32'(pc), 5);
      rst_n = 1'b0;
      #1;
      check("async_rst pc", 32'(pc), 0);
      check("async_rst epoch", 32'(epoch_idx), 0);
      check("async_rst busy", 32'(busy), 0);
      check("async_rst fv", 32'(fetch_valid), 0);
      check("async_rst done", 32'(done), 0);
      @(posedge clock); #1;
      rst_n = 1'b1;
      @(posedge clock); #1;
      $display("[TB] async reset mid-run checked");
      run_prog(6, 2, 0, -1, 1'b0, "post_reset");

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

   // Global watchdog
   initial begin
      #400000;
      $display("FAIL watchdog timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule
